// File: rtl/vctrl_pipe.sv
// vctrl_pipe: control-word pipeline with a vector beat sequencer.
//
// Carries the decoded control word from D through NSTAGE registered stages
// (stage 0 = E, stage NSTAGE-1 = W). A vector op is split into BEATS = VLEN/LANES
// beats. Decode is held, with ready_d low, until the last beat issues. Stall and
// flush insert a bubble into E. Kill discards the D instruction and aborts any beat
// sequence that is in progress.
//
// Optional feature macro: VCTRL_PERF_EN adds the issued-beat and bubble counters.
// When the macro is undefined both counter outputs are tied to zero.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   ctrl_d       in   decoded control word of the instruction in D
//   valid_d      in   D holds a real instruction
//   vec_d        in   D instruction is a multi-beat vector op
//   stall_i      in   hazard stall: nothing issues, bubble into E
//   flush_e      in   bubble into E this cycle
//   kill_d       in   discard the D instruction and abort the beat sequence
//   ready_d      out  D instruction fully consumed this cycle (combinational)
//   ctrl_s       out  stage control words, stage k at [k*CW +: CW]
//   valid_s      out  stage valid bits, bit k = stage k
//   beat_e       out  beat index of the op in E (0 for a scalar op)
//   last_e       out  E holds the final beat (1 for a scalar op)
//   busy         out  sequencer is in the middle of a vector op
//   perf_beats   out  count of issued beats
//   perf_bubbles out  count of cycles where a valid D instruction was held back
module vctrl_pipe #(
   parameter int unsigned CW     = 16,
   parameter int unsigned NSTAGE = 3,
   parameter int unsigned VLEN   = 16,
   parameter int unsigned LANES  = 4,
   localparam int unsigned BEATS = VLEN / LANES,
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [CW-1:0]        ctrl_d,
   input  logic                 valid_d,
   input  logic                 vec_d,
   input  logic                 stall_i,
   input  logic                 flush_e,
   input  logic                 kill_d,
   output logic                 ready_d,
   output logic [NSTAGE*CW-1:0] ctrl_s,
   output logic [NSTAGE-1:0]    valid_s,
   output logic [BW-1:0]        beat_e,
   output logic                 last_e,
   output logic                 busy,
   output logic [31:0]          perf_beats,
   output logic [31:0]          perf_bubbles
);

   // Elaboration-time configuration checks
   if ((VLEN % LANES) != 0) begin : gBadLanes
      $error("vctrl_pipe: VLEN must be a multiple of LANES");
   end
   if (NSTAGE < 1) begin : gBadStages
      $error("vctrl_pipe: NSTAGE must be at least 1");
   end

   localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

   typedef enum logic {
      StIdle,
      StSeq
   } state_t;

   state_t               stateQ, stateD;
   logic [BW-1:0]        cntQ, cntD;
   logic                 issue;
   logic                 readyComb;

   // Next contents of E
   logic                 eValidD;
   logic [CW-1:0]        eCtrlD;
   logic [BW-1:0]        eBeatD;
   logic                 eLastD;

   logic [NSTAGE*CW-1:0] ctrlQ;
   logic [NSTAGE-1:0]    validQ;
   logic [BW-1:0]        beatQ;
   logic                 lastQ;

   assign issue = valid_d & ~stall_i & ~flush_e & ~kill_d;

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      eValidD   = 1'b0;
      eCtrlD    = '0;
      eBeatD    = '0;
      eLastD    = 1'b0;
      readyComb = 1'b0;
      if (kill_d) begin
         // Kill wins over stall/flush; E gets a bubble and decode drops D
         stateD    = StIdle;
         cntD      = '0;
         readyComb = 1'b1;
      end else if (issue) begin
         eValidD = 1'b1;
         eCtrlD  = ctrl_d;
         case (stateQ)
            StIdle: begin
               if (!vec_d || (BEATS == 1)) begin
                  eLastD    = 1'b1;
                  readyComb = 1'b1;
               end else begin
                  cntD   = BW'(1);
                  stateD = StSeq;
               end
            end
            StSeq: begin
               eBeatD = cntQ;
               if (cntQ == LastBeat) begin
                  eLastD    = 1'b1;
                  readyComb = 1'b1;
                  cntD      = '0;
                  stateD    = StIdle;
               end else begin
                  cntD = cntQ + BW'(1);
               end
            end
            default: begin
               stateD = StIdle;
               cntD   = '0;
            end
         endcase
      end
      // Stall or flush without kill: bubble, count held so the beat reissues later
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= StIdle;
         cntQ   <= '0;
         ctrlQ  <= '0;
         validQ <= '0;
         beatQ  <= '0;
         lastQ  <= 1'b0;
      end else begin
         stateQ       <= stateD;
         cntQ         <= cntD;
         ctrlQ[CW-1:0] <= eCtrlD;
         validQ[0]    <= eValidD;
         beatQ        <= eBeatD;
         lastQ        <= eLastD;
         // Downstream stages are never stalled
         for (int k = 1; k < NSTAGE; k++) begin
            ctrlQ[k*CW +: CW] <= ctrlQ[(k-1)*CW +: CW];
            validQ[k]         <= validQ[k-1];
         end
      end
   end

   // Held low during reset so decode never advances on a half-reset pipeline
   assign ready_d = readyComb & reset;
   assign ctrl_s  = ctrlQ;
   assign valid_s = validQ;
   assign beat_e  = beatQ;
   assign last_e  = lastQ;
   assign busy    = (stateQ == StSeq);

`ifdef VCTRL_PERF_EN
   logic [31:0] perfBeatsQ, perfBubblesQ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perfBeatsQ   <= '0;
         perfBubblesQ <= '0;
      end else begin
         if (issue) begin
            perfBeatsQ <= perfBeatsQ + 32'd1;
         end
         // A bubble here means a real instruction was held back, not discarded
         if (valid_d && !issue && !kill_d) begin
            perfBubblesQ <= perfBubblesQ + 32'd1;
         end
      end
   end

   assign perf_beats   = perfBeatsQ;
   assign perf_bubbles = perfBubblesQ;
`else
   assign perf_beats   = '0;
   assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_vctrl_pipe.sv
// Testbench for vctrl_pipe at default parameters. A driver issues one cycle of
// stimulus at a time and pushes the expected E-stage contents into a queue.
// A monitor pops one entry per cycle and checks every stage through a delay line.
module tb_vctrl_pipe;
   localparam int CW     = 16;
   localparam int NSTAGE = 3;
   localparam int VLEN   = 16;
   localparam int LANES  = 4;
   localparam int BEATS  = VLEN / LANES;
   localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic                 clk, reset;
   logic [CW-1:0]        ctrl_d;
   logic                 valid_d, vec_d, stall_i, flush_e, kill_d;
   logic                 ready_d, last_e, busy;
   logic [NSTAGE*CW-1:0] ctrl_s;
   logic [NSTAGE-1:0]    valid_s;
   logic [BW-1:0]        beat_e;
   logic [31:0]          perf_beats, perf_bubbles;

   vctrl_pipe #(.CW(CW), .NSTAGE(NSTAGE), .VLEN(VLEN), .LANES(LANES)) dut (
      .clk(clk), .reset(reset), .ctrl_d(ctrl_d), .valid_d(valid_d), .vec_d(vec_d),
      .stall_i(stall_i), .flush_e(flush_e), .kill_d(kill_d), .ready_d(ready_d),
      .ctrl_s(ctrl_s), .valid_s(valid_s), .beat_e(beat_e), .last_e(last_e), .busy(busy),
      .perf_beats(perf_beats), .perf_bubbles(perf_bubbles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      logic [15:0] c;
      int          beat;
      bit          last;
   } ent_t;

   ent_t eQ[$];
   ent_t dl[NSTAGE];
   int   nChecks = 0;
   int   nPass = 0;
   bit   inReset = 1'b1;

   // Reference model: index of the next beat of the current D instruction
   int          mNext = 0;
   int unsigned mBeats = 0;
   int unsigned mBubbles = 0;
   bit          lastReady = 1'b1;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endfunction

   function automatic void clearModel();
      eQ.delete();
      for (int k = 0; k < NSTAGE; k++) dl[k] = '{v: 0, c: 0, beat: 0, last: 0};
      mNext = 0;
      mBeats = 0;
      mBubbles = 0;
   endfunction

   function automatic void resetChecks();
      chk("rst valid_s", valid_s, 0);
      chk("rst ctrl_s", ctrl_s, 0);
      chk("rst beat_e", beat_e, 0);
      chk("rst last_e", last_e, 0);
      chk("rst busy", busy, 0);
      chk("rst ready_d", ready_d, 0);
      chk("rst perf_beats", perf_beats, 0);
      chk("rst perf_bubbles", perf_bubbles, 0);
   endfunction

   function automatic void perfChecks();
`ifdef VCTRL_PERF_EN
      chk("perf_beats", perf_beats, mBeats);
      chk("perf_bubbles", perf_bubbles, mBubbles);
`else
      chk("perf_beats", perf_beats, 0);
      chk("perf_bubbles", perf_bubbles, 0);
`endif
   endfunction

   // One decode cycle: drive after the falling edge, check combinational/state
   // outputs, then record what E must hold after the next rising edge.
   task automatic cycle(input bit v, input bit vec, input logic [15:0] c,
                        input bit st, input bit fl, input bit kl);
      bit   iss, last, expReady;
      ent_t e;
      @(negedge clk);
      #1;
      valid_d = v; vec_d = vec; ctrl_d = c; stall_i = st; flush_e = fl; kill_d = kl;
      #1;
      iss      = v && !st && !fl && !kl;
      last     = (mNext == BEATS - 1) || (mNext == 0 && !vec);
      expReady = kl || (iss && last);
      chk("ready_d", ready_d, expReady);
      chk("busy", busy, mNext != 0);
      e = '{v: iss, c: iss ? c : 16'h0, beat: iss ? mNext : 0, last: iss && last};
      eQ.push_back(e);
      if (kl) mNext = 0;
      else if (iss) mNext = last ? 0 : mNext + 1;
      if (iss) mBeats++;
      if (v && !iss && !kl) mBubbles++;
      lastReady = expReady;
   endtask

   always @(posedge clk) begin : monitor
      ent_t e;
      #2;
      if (!inReset && eQ.size() > 0) begin
         e = eQ.pop_front();
         for (int k = NSTAGE - 1; k > 0; k--) dl[k] = dl[k-1];
         dl[0] = e;
         for (int k = 0; k < NSTAGE; k++) begin
            chk($sformatf("valid_s[%0d]", k), valid_s[k], dl[k].v);
            chk($sformatf("ctrl_s[%0d]", k), ctrl_s[k*CW +: CW], dl[k].c);
         end
         chk("beat_e", beat_e, dl[0].beat);
         chk("last_e", last_e, dl[0].last);
      end
   end

   initial begin
      bit          curV, curVec;
      logic [15:0] curC;
      reset = 1'b1;
      ctrl_d = 16'h00A5; valid_d = 1'b1; vec_d = 1'b0;
      stall_i = 1'b0; flush_e = 1'b0; kill_d = 1'b0;
      clearModel();
      #2 reset = 1'b0;
      #1 resetChecks();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1; valid_d = 1'b0; inReset = 1'b0;

      // Scalar op, then idle so it drains to W
      cycle(1, 0, 16'h00A5, 0, 0, 0);
      repeat (4) cycle(0, 0, 16'h0, 0, 0, 0);
      // Vector op with decode holding the word
      repeat (BEATS) cycle(1, 1, 16'h1234, 0, 0, 0);
      // Vector op stalled while issuing beat 2
      cycle(1, 1, 16'h4321, 0, 0, 0);
      cycle(1, 1, 16'h4321, 0, 0, 0);
      cycle(1, 1, 16'h4321, 1, 0, 0);
      cycle(1, 1, 16'h4321, 0, 0, 0);
      cycle(1, 1, 16'h4321, 0, 0, 0);
      // Stall and flush together give a single bubble
      cycle(1, 0, 16'h0F0F, 1, 1, 0);
      cycle(1, 0, 16'h0F0F, 0, 0, 0);
      // Kill while two beats have issued, then a fresh op starts at beat 0
      cycle(1, 1, 16'hBEEF, 0, 0, 0);
      cycle(1, 1, 16'hBEEF, 0, 0, 0);
      cycle(1, 1, 16'hBEEF, 1, 0, 1);
      repeat (BEATS) cycle(1, 1, 16'hCAFE, 0, 0, 0);

      // Reset after beat 1 issues; outputs must clear before the next edge
      cycle(1, 1, 16'h5A5A, 0, 0, 0);
      cycle(1, 1, 16'h5A5A, 0, 0, 0);
      @(posedge clk);
      #3 reset = 1'b0; inReset = 1'b1;
      #1 resetChecks();
      clearModel();
      repeat (2) @(posedge clk);
      #3 reset = 1'b1; valid_d = 1'b0; inReset = 1'b0;
      repeat (BEATS) cycle(1, 1, 16'h5A5A, 0, 0, 0);
      repeat (2) cycle(0, 0, 16'h0, 0, 0, 0);
      perfChecks();

      // Fresh counters, then one stalled vector op: 4 beats, 1 bubble
      @(posedge clk);
      #3 reset = 1'b0; inReset = 1'b1;
      clearModel();
      @(posedge clk);
      #3 reset = 1'b1; valid_d = 1'b0; inReset = 1'b0;
      cycle(1, 1, 16'h7777, 0, 0, 0);
      cycle(1, 1, 16'h7777, 0, 0, 0);
      cycle(1, 1, 16'h7777, 0, 1, 0);
      cycle(1, 1, 16'h7777, 0, 0, 0);
      cycle(1, 1, 16'h7777, 0, 0, 0);
      cycle(0, 0, 16'h0, 0, 0, 0);
      perfChecks();

      // Random traffic; decode only advances after ready_d or an empty slot
      lastReady = 1'b1;
      curV = 1'b0; curVec = 1'b0; curC = '0;
      for (int i = 0; i < 1500; i++) begin
         if (lastReady || !curV) begin
            curV   = ($urandom_range(0, 9) < 8);
            curVec = $urandom_range(0, 1) != 0;
            curC   = 16'($urandom);
         end
         cycle(curV, curVec, curC, $urandom_range(0, 99) < 15,
               $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 5);
      end
      cycle(0, 0, 16'h0, 0, 0, 1);
      repeat (NSTAGE + 1) cycle(0, 0, 16'h0, 0, 0, 0);
      perfChecks();
      for (int i = 0; i < 20 && eQ.size() > 0; i++) @(negedge clk);
      chk("scoreboard drained", eQ.size(), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
